// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle between N requesters and a
// round-robin arbiter guarding one shared resource.
//   req         requester -> arbiter, level request vector (bit i = requester i)
//   done        resource  -> arbiter, one-cycle "transaction finished" pulse
//   grant       arbiter   -> requesters, one-hot grant (0 when idle)
//   grant_idx   arbiter   -> requesters, binary index of the grant (0 when idle)
//   grant_valid arbiter   -> requesters, high while a grant is held
//   timeout     arbiter   -> requesters, one-cycle pulse on forced revocation
// Modports: master = requester/resource side, slave = arbiter side.
interface rr_grant_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_valid;
  logic            timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter sharing one resource among N
// requesters. A grant is held until the resource pulses done; on release the
// priority pointer moves to the released winner and, if anyone is still
// requesting, the next winner is granted on the following cycle with no idle
// bubble. All outputs are registered.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_grant_arbiter_if.slave (req, done in; grant, grant_idx,
//          grant_valid, timeout out)
// Parameters:
//   N         number of requesters (>= 1, any value)
//   MAX_HOLD  maximum grant length in cycles (>= 2), used only when the
//             RR_ARB_TIMEOUT_EN macro is defined
// Build option:
//   RR_ARB_TIMEOUT_EN  adds a hold counter that revokes a grant after
//                      MAX_HOLD cycles and pulses timeout; without it timeout
//                      is constant 0 and grants last until done.
module rr_grant_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_grant_arbiter_if.slave   bus
);

  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SUMW = IDXW + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Elaboration-time parameter sanity checks
  if (N < 1) begin : g_bad_n
    $error("rr_grant_arbiter: N must be >= 1");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_grant_arbiter: MAX_HOLD must be >= 2");
  end

  logic [0:0]      state_q, state_n;
  logic [IDXW-1:0] ptr_q, ptr_n;
  logic [N-1:0]    grant_q, grant_n;
  logic [IDXW-1:0] idx_q, idx_n;
  logic            valid_q, valid_n;

  logic            load_c;
  logic            release_c;
  logic            expire_c;

  logic [IDXW-1:0] arb_ptr_c;
  logic [IDXW-1:0] arb_start_c;
  logic [IDXW-1:0] arb_win_c;
  logic [2*N-1:0]  req_dbl_c;
  logic [N-1:0]    req_rot_c;
  logic [SUMW-1:0] arb_off_c;
  logic [SUMW-1:0] arb_sum_c;

  // Rotated priority encode. While a grant is held the pointer used is the
  // current winner, so a release re-arbitrates against the updated pointer.
  // Start index wraps explicitly so non-power-of-two N is handled.
  always_comb begin
    arb_ptr_c   = (state_q == ST_GRANT) ? idx_q : ptr_q;
    arb_start_c = (arb_ptr_c == IDXW'(N - 1)) ? '0 : arb_ptr_c + IDXW'(1);
    req_dbl_c   = {bus.req, bus.req};
    req_rot_c   = N'(req_dbl_c >> arb_start_c);
    arb_off_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_rot_c[i]) begin
        arb_off_c = SUMW'(i);
      end
    end
    arb_sum_c = SUMW'(arb_start_c) + arb_off_c;
    if (arb_sum_c >= SUMW'(N)) begin
      arb_sum_c = arb_sum_c - SUMW'(N);
    end
    arb_win_c = arb_sum_c[IDXW-1:0];
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    grant_n = grant_q;
    idx_n   = idx_q;
    valid_n = valid_q;
    load_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          load_c  = 1'b1;
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          ptr_n = idx_q;
          if (|bus.req) begin
            load_c = 1'b1;
          end else begin
            state_n = ST_IDLE;
            grant_n = '0;
            idx_n   = '0;
            valid_n = 1'b0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (load_c) begin
      grant_n = N'(1) << arb_win_c;
      idx_n   = arb_win_c;
      valid_n = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDXW'(N - 1);
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      grant_q <= grant_n;
      idx_q   <= idx_n;
      valid_q <= valid_n;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CNTW = $clog2(MAX_HOLD);

  logic [CNTW-1:0] hold_q, hold_n;
  logic            timeout_q, timeout_n;

  // Hold counter: cycles the current grant has been visible
  always_comb begin
    hold_n    = '0;
    timeout_n = 1'b0;
    if (state_n == ST_GRANT && !load_c) begin
      hold_n = hold_q + CNTW'(1);
    end
    // A done coinciding with expiry is a normal release
    if (expire_c && !bus.done) begin
      timeout_n = 1'b1;
    end
  end

  assign expire_c = (state_q == ST_GRANT) && (hold_q == CNTW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_n;
      timeout_q <= timeout_n;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire_c    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign release_c = bus.done | expire_c;

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: self-checking bench for rr_grant_arbiter. Drives an
// N=4 and an N=3 instance (MAX_HOLD=8), compares against a vector table,
// hand-written sequences and a behavioural round-robin model.
module tb_rr_grant_arbiter;

  localparam int unsigned MAXH = 8;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  rr_grant_arbiter_if #(.N(4)) if4 ();
  rr_grant_arbiter_if #(.N(3)) if3 ();

  rr_grant_arbiter #(.N(4), .MAX_HOLD(MAXH)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  rr_grant_arbiter #(.N(3), .MAX_HOLD(MAXH)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model of the N=4 instance: visible state after each edge
  bit m_busy;
  int m_win;
  int m_ptr;
  int m_hold;
  bit m_to;

  function automatic int pick(input int ptr, input logic [3:0] r, input int n);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (ptr + k) % n;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_win  = 0;
    m_ptr  = 3;
    m_hold = 0;
    m_to   = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    bit expire;
    m_to = 1'b0;
    if (!m_busy) begin
      if (r != 4'b0) begin
        m_win  = pick(m_ptr, r, 4);
        m_busy = 1'b1;
        m_hold = 0;
      end
    end else begin
      expire = TO_EN && (m_hold == int'(MAXH) - 1);
      if (d || expire) begin
        m_to  = !d;
        m_ptr = m_win;
        if (r != 4'b0) begin
          m_win  = pick(m_ptr, r, 4);
          m_hold = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = m_busy ? 4'(1 << m_win) : 4'b0;
    check({tag, "_grant"},   32'(if4.grant),       32'(eg));
    check({tag, "_idx"},     32'(if4.grant_idx),   m_busy ? 32'(m_win) : 32'd0);
    check({tag, "_valid"},   32'(if4.grant_valid), 32'(m_busy));
    check({tag, "_timeout"}, 32'(if4.timeout),     32'(m_to));
  endtask

  // One clock on the N=4 instance with model tracking and checking
  task automatic step(input logic [3:0] r, input logic d);
    if4.req  = r;
    if4.done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    if4.done = 1'b0;
    check_model("model");
  endtask

  // One clock on the N=3 instance (N=4 instance left idle)
  task automatic step3(input logic [2:0] r, input logic d, input logic [1:0] ei, input logic ev);
    logic [2:0] eg;
    if3.req  = r;
    if3.done = d;
    if4.req  = 4'b0;
    if4.done = 1'b0;
    @(posedge clk);
    #1;
    if3.done = 1'b0;
    eg = ev ? 3'(1 << ei) : 3'b0;
    check("n3_grant", 32'(if3.grant),       32'(eg));
    check("n3_idx",   32'(if3.grant_idx),   32'(ei));
    check("n3_valid", 32'(if3.grant_valid), 32'(ev));
  endtask

  // Asynchronous reset; outputs must clear before any clock edge
  task automatic do_reset();
    rst_n    = 1'b0;
    if4.req  = 4'b0;
    if4.done = 1'b0;
    if3.req  = 3'b0;
    if3.done = 1'b0;
    model_reset();
    #2;
    check_model("rst");
    check("rst_n3_grant", 32'(if3.grant), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  vec_t vt[15];
  int   exp_seq[6] = '{0, 1, 2, 3, 0, 1};
  int   seq[$];
  int   held;

  initial begin
    // latency, hold, idle done ignored, wrap/skip, sole requester, rotation
    vt[0]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
    vt[1]  = '{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1};
    vt[2]  = '{4'b1011, 1'b0, 4'b0100, 2'd2, 1'b1};
    vt[3]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    vt[4]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    vt[5]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
    vt[6]  = '{4'b1011, 1'b1, 4'b1000, 2'd3, 1'b1};
    vt[7]  = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1};
    vt[8]  = '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1};
    vt[9]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vt[10] = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    vt[11] = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
    vt[12] = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    vt[13] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
    vt[14] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};

    rst_n    = 1'b1;
    if4.req  = 4'b0;
    if4.done = 1'b0;
    if3.req  = 3'b0;
    if3.done = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Vector table
    for (int v = 0; v < 15; v++) begin
      step(vt[v].req, vt[v].done);
      check($sformatf("vec%0d_grant", v), 32'(if4.grant),       32'(vt[v].grant));
      check($sformatf("vec%0d_idx", v),   32'(if4.grant_idx),   32'(vt[v].idx));
      check($sformatf("vec%0d_valid", v), 32'(if4.grant_valid), 32'(vt[v].valid));
    end

    // Hold: single-cycle request, done in the fifth grant cycle
    held = 0;
    step(4'b0100, 1'b0);
    if (if4.grant == 4'b0100 && if4.grant_idx == 2'd2) held++;
    for (int c = 0; c < 3; c++) begin
      step(4'b0000, 1'b0);
      if (if4.grant == 4'b0100 && if4.grant_idx == 2'd2) held++;
    end
    step(4'b0000, 1'b0);
    if (if4.grant == 4'b0100 && if4.grant_idx == 2'd2) held++;
    check("hold_cycles", 32'(held), 32'd5);
    step(4'b0000, 1'b1);
    check("hold_idle_grant", 32'(if4.grant), 32'd0);

    // Non-power-of-two N=3 rotation
    step3(3'b111, 1'b0, 2'd0, 1'b1);
    step3(3'b111, 1'b1, 2'd1, 1'b1);
    step3(3'b111, 1'b1, 2'd2, 1'b1);
    step3(3'b111, 1'b1, 2'd0, 1'b1);
    step3(3'b000, 1'b1, 2'd0, 1'b0);

    // Fairness with all requesting, done two cycles into each grant
    do_reset();
    seq.delete();
    step(4'b1111, 1'b0);
    seq.push_back(int'(if4.grant_idx));
    for (int g = 1; g < 6; g++) begin
      step(4'b1111, 1'b0);
      check("fair_valid_hold", 32'(if4.grant_valid), 32'd1);
      step(4'b1111, 1'b1);
      check("fair_valid_switch", 32'(if4.grant_valid), 32'd1);
      seq.push_back(int'(if4.grant_idx));
    end
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fair_seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    end

    // Reset while a grant is held, then restart from the reset pointer
    check("pre_reset_valid", 32'(if4.grant_valid), 32'd1);
    do_reset();
    step(4'b1000, 1'b0);
    check("post_reset_grant", 32'(if4.grant), 32'b1000);
    step(4'b0000, 1'b1);

`ifdef RR_ARB_TIMEOUT_EN
    // Forced revocation after MAX_HOLD cycles
    do_reset();
    held = 0;
    step(4'b0001, 1'b0);
    if (if4.grant == 4'b0001) held++;
    for (int c = 0; c < 7; c++) begin
      step(4'b0011, 1'b0);
      if (if4.grant == 4'b0001) held++;
      check("to_quiet", 32'(if4.timeout), 32'd0);
    end
    check("to_held", 32'(held), 32'd8);
    step(4'b0011, 1'b0);
    check("to_pulse", 32'(if4.timeout), 32'd1);
    check("to_idx", 32'(if4.grant_idx), 32'd1);
    step(4'b0011, 1'b0);
    check("to_once", 32'(if4.timeout), 32'd0);
    for (int c = 0; c < 6; c++) begin
      step(4'b0011, 1'b0);
    end
    step(4'b0011, 1'b1);
    check("to_done_at_expiry", 32'(if4.timeout), 32'd0);
    check("to_done_at_expiry_idx", 32'(if4.grant_idx), 32'd0);
    step(4'b0000, 1'b1);
`else
    // Without the timeout option a grant lasts until done
    do_reset();
    step(4'b0001, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(4'b0011, 1'b0);
    end
    check("nodone_grant", 32'(if4.grant), 32'b0001);
    check("nodone_timeout", 32'(if4.timeout), 32'd0);
    step(4'b0000, 1'b1);
`endif

    // Random traffic against the model
    for (int t = 0; t < 400; t++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter sharing one resource (bus port, shared datapath unit) between N requesters.
- Grants one requester at a time and holds the grant until the resource signals done.
- Rotates priority so every requester is granted within N grant periods.
- Winner selection is a rotated priority-encode. Results are registered, and back-to-back grants have no idle bubble.

Parameters:
- N, 4, number of requesters (N >= 1, any value, not restricted to a power of two).
- MAX_HOLD, 16, maximum grant length in cycles. Used only with RR_ARB_TIMEOUT_EN. MAX_HOLD >= 2.
- IDXW, $clog2(N) with a minimum of 1, localparam, width of grant_idx.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request vector. Bit i = requester i wants the resource. Level-sensitive.
- done  input  1  one-cycle pulse from the resource: current transaction finished, release the grant.
- grant  output  N  one-hot grant, registered. All zeros when idle.
- grant_idx  output  IDXW  binary index of the granted requester. 0 when idle.
- grant_valid  output  1  high while any grant is held. Equals |grant.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked. Constant 0 without the macro.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE, grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0.
  - Priority pointer ptr = N-1, so requester 0 has highest priority first.
  - Hold counter = 0.
- Arbitration function:
  - Search req starting at index (ptr+1) mod N, upward with wrap-around.
  - The first set bit wins.
  - ptr+1 wraps to 0 when ptr = N-1. This must be correct for non-power-of-two N (no reliance on natural overflow).
- IDLE:
  - If req != 0: register the winner and go to GRANT.
  - grant, grant_idx and grant_valid become visible the next cycle (latency 1 from req).
  - If req == 0: stay in IDLE.
  - done in IDLE is ignored.
- GRANT:
  - Outputs are held stable. req is ignored, including the granted requester dropping its own req.
  - On done:
    - ptr <= current winner.
    - If any bit of req is set that cycle, re-arbitrate with the updated ptr. The new grant appears the next cycle with no idle cycle, and state stays GRANT.
    - The current winner wins again only if it is the sole requester.
    - If req == 0, return to IDLE and drop outputs to 0 the next cycle.
  - done and a req change in the same cycle: the arbitration uses that cycle's req.
- N = 1: grant[0] follows the protocol above. The pointer is a constant.
- Reset asserted mid-grant:
  - Outputs clear immediately, without waiting for a clock.
  - No done is owed to the resource.
  - After reset release, arbitration restarts from ptr = N-1.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- With the macro defined:
  - The hold counter clears on every new grant and increments each cycle in GRANT.
  - If done has not arrived when the counter reaches MAX_HOLD-1, the grant is revoked as if done had arrived. This includes pointer update and back-to-back re-arbitration.
  - timeout pulses high for exactly one cycle, aligned with the first cycle after revocation.
  - done arriving in the same cycle as expiry counts as a normal done, and timeout is not pulsed.
- Without the macro: no counter is built, timeout is tied to 0, and grants are held indefinitely until done.

Test Plan:
- Reset check: assert rst_n = 0 mid-simulation while a grant is active -> grant = 0, grant_idx = 0, grant_valid = 0, timeout = 0 before the next clk edge. After release with req = 4'b1000, grant = 4'b1000 one cycle later.
- Fairness, N = 4: req = 4'b1111 held, done pulsed 2 cycles after each grant -> grant_idx sequence 0,1,2,3,0,1, with no cycle where grant_valid = 0 after the first grant.
- Hold: req = 4'b0100 for 1 cycle then 0, done after 5 cycles -> grant = 4'b0100 and grant_idx = 2 for exactly 5 cycles, then IDLE, all outputs 0.
- Wrap and skip: winner = 1, req = 4'b1011 when done pulses -> next cycle grant_idx = 3. On the next done with req = 4'b0011 -> grant_idx = 0.
- Non-power-of-two, N = 3: req = 3'b111 -> grant_idx 0,1,2,0. grant_idx never equals 3.
- Timeout (macro on, MAX_HOLD = 8, N = 4): grant to 0, never pulse done, req = 4'b0011 -> grant held 8 cycles, timeout high 1 cycle, grant_idx = 1 in that same cycle.
